// File: rtl/rect_motion_ctrl.sv
// Frame-synchronous position/colour controller for the bouncing-rectangle demo.
// Detects entry to vertical blanking and steps the rectangle, reflecting off the active-area edges.
module rect_motion_ctrl #(
  parameter int H_ACTIVE  = 640,
  parameter int V_ACTIVE  = 480,
  parameter int RECT_W    = 64,
  parameter int RECT_H    = 48,
  parameter int STEP_X    = 2,
  parameter int STEP_Y    = 2,
  parameter int FRAME_DIV = 1,
  parameter int INIT_X    = 100,
  parameter int INIT_Y    = 50
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [9:0] vcount,
  input  logic       enable,
  output logic [9:0] rect_x,
  output logic [9:0] rect_y,
  output logic [2:0] color,
  output logic       frame_tick,
  output logic       bounce
);

  localparam int          CNT_W   = (FRAME_DIV > 1) ? $clog2(FRAME_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(FRAME_DIV - 1);
  localparam logic [9:0]  V_BLANK = 10'(V_ACTIVE);
  localparam logic [10:0] MAX_X   = 11'(H_ACTIVE - RECT_W);
  localparam logic [10:0] MAX_Y   = 11'(V_ACTIVE - RECT_H);
  localparam logic [10:0] STEP_X_W = 11'(STEP_X);
  localparam logic [10:0] STEP_Y_W = 11'(STEP_Y);

  typedef enum logic [1:0] {WAIT, UPD_X, UPD_Y} state_t;

  typedef struct packed {
    logic [9:0] pos;
    logic       dir_neg;
    logic       hit;
  } axis_t;

  // One reflecting step along an axis; 11-bit compare so pos+step cannot wrap.
  function automatic axis_t step_axis(input logic [9:0] pos, input logic dir_neg,
                                      input logic [10:0] step, input logic [10:0] max_pos);
    axis_t      r;
    logic [10:0] sum;
    sum       = {1'b0, pos} + step;
    r.pos     = pos;
    r.dir_neg = dir_neg;
    r.hit     = 1'b0;
    if (!dir_neg) begin
      if (sum >= max_pos) begin
        r.pos = max_pos[9:0]; r.dir_neg = 1'b1; r.hit = 1'b1;
      end else begin
        r.pos = sum[9:0];
      end
    end else begin
      if ({1'b0, pos} <= step) begin
        r.pos = '0; r.dir_neg = 1'b0; r.hit = 1'b1;
      end else begin
        r.pos = pos - step[9:0];
      end
    end
    return r;
  endfunction

  state_t           state, state_nx;
  logic [9:0]       vcount_q;
  logic [CNT_W-1:0] frame_cnt;
  logic             dir_x_neg, dir_y_neg, hit_x;
  logic             div_hit;
  axis_t            ax, ay;
  logic [2:0]       color_inc, color_nx;

  assign ax        = step_axis(rect_x, dir_x_neg, STEP_X_W, MAX_X);
  assign ay        = step_axis(rect_y, dir_y_neg, STEP_Y_W, MAX_Y);
  assign color_inc = color + 3'd1;
  assign color_nx  = (color_inc == 3'd0) ? 3'd1 : color_inc;
  assign div_hit   = (state == WAIT) && frame_tick && enable;

  // NOTE: next-state gets its default before the case so no path leaves it unassigned (no latch).
  always_comb begin
    state_nx = state;
    case (state)
      WAIT:    if (div_hit && frame_cnt == CNT_MAX) state_nx = UPD_X;
      UPD_X:   state_nx = UPD_Y;
      UPD_Y:   state_nx = WAIT;
      default: state_nx = WAIT;
    endcase
  end

  // NOTE: all state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= WAIT;
      vcount_q   <= V_BLANK;
      frame_tick <= 1'b0;
      frame_cnt  <= '0;
      rect_x     <= 10'(INIT_X);
      rect_y     <= 10'(INIT_Y);
      dir_x_neg  <= 1'b0;
      dir_y_neg  <= 1'b0;
      hit_x      <= 1'b0;
      color      <= 3'b001;
      bounce     <= 1'b0;
    end else begin
      state      <= state_nx;
      vcount_q   <= vcount;
      frame_tick <= (vcount == V_BLANK) && (vcount_q != V_BLANK);
      bounce     <= 1'b0;
      if (div_hit) frame_cnt <= (frame_cnt == CNT_MAX) ? '0 : frame_cnt + CNT_W'(1);
      case (state)
        WAIT: hit_x <= 1'b0;
        UPD_X: begin
          rect_x    <= ax.pos;
          dir_x_neg <= ax.dir_neg;
          hit_x     <= ax.hit;
        end
        UPD_Y: begin
          rect_y    <= ay.pos;
          dir_y_neg <= ay.dir_neg;
          // A corner hit still advances the colour only once.
          if (hit_x || ay.hit) begin
            color  <= color_nx;
            bounce <= 1'b1;
          end
        end
        default: hit_x <= 1'b0;
      endcase
    end
  end

endmodule

// File: tb/tb_rect_motion_ctrl.sv
// Directed bench for rect_motion_ctrl: five differently-parameterised instances share clk/vcount/rst,
// each enabled only while it is the one under test.
module tb_rect_motion_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [9:0] vcount = 10'd480;
  logic       en   [5];
  logic [9:0] x    [5];
  logic [9:0] y    [5];
  logic [2:0] col  [5];
  logic       tick [5];
  logic       bnc  [5];

  int n_cmp  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  // 0: defaults, 1: right edge, 2: corner, 3: divider, 4: narrow track for left wrap / colour wrap
  rect_motion_ctrl u_a (.clk(clk), .rst(rst), .vcount(vcount), .enable(en[0]),
    .rect_x(x[0]), .rect_y(y[0]), .color(col[0]), .frame_tick(tick[0]), .bounce(bnc[0]));
  rect_motion_ctrl #(.INIT_X(575)) u_b (.clk(clk), .rst(rst), .vcount(vcount), .enable(en[1]),
    .rect_x(x[1]), .rect_y(y[1]), .color(col[1]), .frame_tick(tick[1]), .bounce(bnc[1]));
  rect_motion_ctrl #(.INIT_X(575), .INIT_Y(431)) u_c (.clk(clk), .rst(rst), .vcount(vcount),
    .enable(en[2]), .rect_x(x[2]), .rect_y(y[2]), .color(col[2]), .frame_tick(tick[2]), .bounce(bnc[2]));
  rect_motion_ctrl #(.FRAME_DIV(3)) u_d (.clk(clk), .rst(rst), .vcount(vcount), .enable(en[3]),
    .rect_x(x[3]), .rect_y(y[3]), .color(col[3]), .frame_tick(tick[3]), .bounce(bnc[3]));
  rect_motion_ctrl #(.H_ACTIVE(16), .RECT_W(13), .INIT_X(1)) u_e (.clk(clk), .rst(rst),
    .vcount(vcount), .enable(en[4]), .rect_x(x[4]), .rect_y(y[4]), .color(col[4]),
    .frame_tick(tick[4]), .bounce(bnc[4]));

  typedef struct {
    int   inst;
    logic en;
    int   x;
    int   y;
    int   c;
    logic b;
  } vec_t;

  vec_t tbl[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic add(input int inst, input logic e, input int xx, input int yy, input int c, input logic b);
    vec_t v;
    v.inst = inst; v.en = e; v.x = xx; v.y = yy; v.c = c; v.b = b;
    tbl.push_back(v);
  endtask

  task automatic select(input int k, input logic e);
    for (int j = 0; j < 5; j++) en[j] = 1'b0;
    en[k] = e;
  endtask

  // Ends on the negedge where rect_y/color/bounce of the frame's update are visible.
  task automatic run_frame(input int k);
    @(negedge clk) vcount = 10'd479;
    @(negedge clk);
    @(negedge clk) vcount = 10'd480;
    @(negedge clk) check($sformatf("tick_on_i%0d", k), 32'(tick[k]), 32'd1);
    @(negedge clk) check($sformatf("tick_off_i%0d", k), 32'(tick[k]), 32'd0);
    @(negedge clk);
    @(negedge clk);
  endtask

  initial begin
    for (int j = 0; j < 5; j++) en[j] = 1'b0;

    // Right-edge bounce, then move back left.
    add(1, 1, 576, 52, 2, 1);
    add(1, 1, 574, 54, 2, 0);
    // Corner bounce: one pulse, one colour step, both axes reverse.
    add(2, 1, 576, 432, 2, 1);
    add(2, 1, 574, 430, 2, 0);
    // Divide-by-3, then 4 disabled frames, then the held count resumes.
    add(3, 1, 100, 50, 1, 0);
    add(3, 1, 100, 50, 1, 0);
    add(3, 1, 102, 52, 1, 0);
    add(3, 1, 102, 52, 1, 0);
    for (int i = 0; i < 4; i++) add(3, 0, 102, 52, 1, 0);
    add(3, 1, 102, 52, 1, 0);
    add(3, 1, 104, 54, 1, 0);
    // Narrow track (MAX_X=3): left wrap at x=1 and colour wrap 111->001.
    add(4, 1, 3, 52, 2, 1);
    add(4, 1, 1, 54, 2, 0);
    add(4, 1, 0, 56, 3, 1);
    add(4, 1, 2, 58, 3, 0);
    add(4, 1, 3, 60, 4, 1);
    add(4, 1, 1, 62, 4, 0);
    add(4, 1, 0, 64, 5, 1);
    add(4, 1, 2, 66, 5, 0);
    add(4, 1, 3, 68, 6, 1);
    add(4, 1, 1, 70, 6, 0);
    add(4, 1, 0, 72, 7, 1);
    add(4, 1, 2, 74, 7, 0);
    add(4, 1, 3, 76, 1, 1);
    add(4, 1, 1, 78, 1, 0);

    // Reset with vcount already in blanking: no tick after release.
    repeat (3) @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check($sformatf("init_no_tick_%0d", i), 32'(tick[0]), 32'd0);
    end
    check("init_x", 32'(x[0]), 32'd100);
    check("init_y", 32'(y[0]), 32'd50);
    check("init_color", 32'(col[0]), 32'd1);
    check("init_bounce", 32'(bnc[0]), 32'd0);

    // Cycle-by-cycle latency on the default instance.
    select(0, 1'b1);
    @(negedge clk) vcount = 10'd479;
    @(negedge clk);
    check("lat_pre_tick", 32'(tick[0]), 32'd0);
    vcount = 10'd480;
    @(negedge clk);
    check("lat_tick_on", 32'(tick[0]), 32'd1);
    check("lat_x_c1", 32'(x[0]), 32'd100);
    @(negedge clk);
    check("lat_tick_off", 32'(tick[0]), 32'd0);
    check("lat_x_c2", 32'(x[0]), 32'd100);
    @(negedge clk);
    check("lat_x_c3", 32'(x[0]), 32'd102);
    check("lat_y_c3", 32'(y[0]), 32'd50);
    @(negedge clk);
    check("lat_y_c4", 32'(y[0]), 32'd52);
    check("lat_color_c4", 32'(col[0]), 32'd1);
    check("lat_bounce_c4", 32'(bnc[0]), 32'd0);
    @(negedge clk);
    check("lat_tick_held", 32'(tick[0]), 32'd0);

    foreach (tbl[i]) begin
      select(tbl[i].inst, tbl[i].en);
      run_frame(tbl[i].inst);
      check($sformatf("v%0d_x", i), 32'(x[tbl[i].inst]), 32'(tbl[i].x));
      check($sformatf("v%0d_y", i), 32'(y[tbl[i].inst]), 32'(tbl[i].y));
      check($sformatf("v%0d_color", i), 32'(col[tbl[i].inst]), 32'(tbl[i].c));
      check($sformatf("v%0d_bounce", i), 32'(bnc[tbl[i].inst]), 32'(tbl[i].b));
      @(negedge clk);
      check($sformatf("v%0d_bounce_1clk", i), 32'(bnc[tbl[i].inst]), 32'd0);
    end

    // Reset landing on the UPD_Y edge discards the half-done update.
    select(4, 1'b1);
    @(negedge clk) vcount = 10'd479;
    @(negedge clk);
    @(negedge clk) vcount = 10'd480;
    repeat (3) @(negedge clk);
    check("rst_mid_x_moved", 32'(x[4]), 32'd0);
    check("rst_mid_y_old", 32'(y[4]), 32'd78);
    rst = 1'b1;
    @(negedge clk);
    check("rst_mid_x", 32'(x[4]), 32'd1);
    check("rst_mid_y", 32'(y[4]), 32'd50);
    check("rst_mid_color", 32'(col[4]), 32'd1);
    check("rst_mid_bounce", 32'(bnc[4]), 32'd0);
    check("rst_mid_tick", 32'(tick[4]), 32'd0);
    rst = 1'b0;
    // Direction restored to +: 1 -> 3 hits the right edge.
    run_frame(4);
    check("post_rst_x", 32'(x[4]), 32'd3);
    check("post_rst_y", 32'(y[4]), 32'd52);
    check("post_rst_color", 32'(col[4]), 32'd2);
    check("post_rst_bounce", 32'(bnc[4]), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
